// File: rtl/rx_lane_fifo.sv
// rx_lane_fifo: four independent per-lane circular FIFOs behind the 1:4 demux.
// Each lane buffers 2^ADDR_W bytes and raises occupancy flags. An aggregate
// pause is the OR of the lane almost-full flags.
// Optional feature macro: RX_LANE_FIFO_OVF_EN. When it is defined, a sticky
// per-lane overflow bit records dropped pushes. Without it, overflow ties to 0.
module rx_lane_fifo #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ADDR_W    = 2,
  parameter int unsigned AF_THRESH = 3,
  parameter int unsigned AE_THRESH = 1
) (
  input  logic              clk1f,
  input  logic              reset,
  input  logic [DATA_W-1:0] in0,
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  input  logic [DATA_W-1:0] in3,
  input  logic [3:0]        valid_in,
  input  logic [3:0]        pop,
  output logic [DATA_W-1:0] out0,
  output logic [DATA_W-1:0] out1,
  output logic [DATA_W-1:0] out2,
  output logic [DATA_W-1:0] out3,
  output logic [3:0]        valid_out,
  output logic [3:0]        full,
  output logic [3:0]        empty,
  output logic [3:0]        almost_full,
  output logic [3:0]        almost_empty,
  output logic              pause,
  output logic [3:0]        overflow
);

  localparam int unsigned LANES = 4;
  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [DATA_W-1:0] in_lane [LANES];
  logic [DATA_W-1:0] mem_q   [LANES][DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q [LANES];
  logic [ADDR_W-1:0] wr_ptr_d [LANES];
  logic [ADDR_W-1:0] rd_ptr_q [LANES];
  logic [ADDR_W-1:0] rd_ptr_d [LANES];
  logic [CNT_W-1:0]  cnt_q    [LANES];
  logic [CNT_W-1:0]  cnt_d    [LANES];
  logic [DATA_W-1:0] dout_q   [LANES];
  logic [DATA_W-1:0] dout_d   [LANES];
  logic [3:0]        vout_q, vout_d;
  logic [3:0]        push_ok, pop_ok;

  assign in_lane[0] = in0;
  assign in_lane[1] = in1;
  assign in_lane[2] = in2;
  assign in_lane[3] = in3;

  // Per-lane accept decisions, pointer/count updates and read data.
  always_comb begin
    push_ok = 4'b0;
    pop_ok  = 4'b0;
    vout_d  = 4'b0;
    for (int k = 0; k < LANES; k++) begin
      wr_ptr_d[k] = wr_ptr_q[k];
      rd_ptr_d[k] = rd_ptr_q[k];
      cnt_d[k]    = cnt_q[k];
      dout_d[k]   = dout_q[k];
      pop_ok[k]   = pop[k] && (cnt_q[k] != CNT_W'(0));
      // A full lane still takes a push when a pop frees a slot this cycle.
      push_ok[k]  = valid_in[k] && ((cnt_q[k] != CNT_W'(DEPTH)) || pop_ok[k]);
      if (push_ok[k]) wr_ptr_d[k] = wr_ptr_q[k] + ADDR_W'(1);
      if (pop_ok[k]) begin
        rd_ptr_d[k] = rd_ptr_q[k] + ADDR_W'(1);
        dout_d[k]   = mem_q[k][rd_ptr_q[k]];
        vout_d[k]   = 1'b1;
      end
      if (push_ok[k] && !pop_ok[k])      cnt_d[k] = cnt_q[k] + CNT_W'(1);
      else if (!push_ok[k] && pop_ok[k]) cnt_d[k] = cnt_q[k] - CNT_W'(1);
    end
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge clk1f) begin
    if (!reset) begin
      vout_q <= 4'b0;
      for (int k = 0; k < LANES; k++) begin
        wr_ptr_q[k] <= '0;
        rd_ptr_q[k] <= '0;
        cnt_q[k]    <= '0;
        dout_q[k]   <= '0;
      end
    end else begin
      vout_q <= vout_d;
      for (int k = 0; k < LANES; k++) begin
        wr_ptr_q[k] <= wr_ptr_d[k];
        rd_ptr_q[k] <= rd_ptr_d[k];
        cnt_q[k]    <= cnt_d[k];
        dout_q[k]   <= dout_d[k];
      end
    end
  end

  // Storage writes. The array is not cleared, and writes are blocked during reset.
  always_ff @(posedge clk1f) begin
    if (reset) begin
      for (int k = 0; k < LANES; k++) begin
        if (push_ok[k]) mem_q[k][wr_ptr_q[k]] <= in_lane[k];
      end
    end
  end

  // Occupancy flags decoded from registered counts.
  always_comb begin
    full         = 4'b0;
    empty        = 4'b0;
    almost_full  = 4'b0;
    almost_empty = 4'b0;
    for (int k = 0; k < LANES; k++) begin
      full[k]         = (cnt_q[k] == CNT_W'(DEPTH));
      empty[k]        = (cnt_q[k] == CNT_W'(0));
      almost_full[k]  = (cnt_q[k] >= CNT_W'(AF_THRESH));
      almost_empty[k] = (cnt_q[k] <= CNT_W'(AE_THRESH));
    end
  end

  assign pause     = |almost_full;
  assign valid_out = vout_q;
  assign out0      = dout_q[0];
  assign out1      = dout_q[1];
  assign out2      = dout_q[2];
  assign out3      = dout_q[3];

`ifdef RX_LANE_FIFO_OVF_EN
  logic [3:0] ovf_q, ovf_d;

  // Sticky drop indicator: set by a push that is rejected on a full lane.
  always_comb begin
    ovf_d = ovf_q | (valid_in & ~push_ok);
  end

  // Overflow register, cleared only by reset.
  always_ff @(posedge clk1f) begin
    if (!reset) ovf_q <= 4'b0;
    else        ovf_q <= ovf_d;
  end

  assign overflow = ovf_q;
`else
  assign overflow = 4'b0;
`endif

endmodule
